regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised general-purpose register file: 2 async read ports, 1 sync write port, per-register scoreboard (busy bits).
- Replaces the fixed 4x8 file in the CPU datapath.
- Adds sequential post-reset init sweep, a reservation port for multi-cycle producers, and optional same-cycle write-to-read bypass.
- Sits between decode (reads/reserves) and writeback (writes).

Parameters:
- DATA_W, 8, register width in bits
- NUM_REGS, 4, number of registers; power of two, >= 2
- ADDR_W, $clog2(NUM_REGS), address width (derived; do not override)

Ports:
- clk  in  1  clock
- sync_rst  in  1  synchronous active-high reset
- read_en_A  in  1  enable read port A
- read_en_B  in  1  enable read port B
- addr_read_A  in  ADDR_W  read address A
- addr_read_B  in  ADDR_W  read address B
- data_out_A  out  DATA_W  read data A; 0 when disabled
- data_out_B  out  DATA_W  read data B; 0 when disabled
- busy_A  out  1  addr_read_A has a pending reservation; 0 when read_en_A low
- busy_B  out  1  addr_read_B has a pending reservation; 0 when read_en_B low
- write_en  in  1  write strobe
- addr_write  in  ADDR_W  write address
- data_in  in  DATA_W  write data
- rsv_en  in  1  reserve strobe; marks rsv_addr busy
- rsv_addr  in  ADDR_W  register to reserve
- ready  out  1  init sweep complete; file accepts writes and reservations

Behaviour:
- One clock (clk). Reset is synchronous and active-high (sync_rst).
- FSM states: INIT and RUN.
  - sync_rst high: state <- INIT, sweep counter <- 0, all busy bits <- 0, ready <- 0. Same rule applies mid-sweep and mid-RUN.
  - INIT: each cycle writes init value to regs[counter], then counter++.
    - Init value: regs[i] = i truncated to DATA_W, except regs[NUM_REGS-1] = 0.
    - After writing index NUM_REGS-1: -> RUN, ready = 1 from the next cycle.
    - Sweep takes exactly NUM_REGS cycles after sync_rst deasserts.
  - RUN: terminal until next reset.
- INIT rules:
  - write_en and rsv_en are ignored.
  - Reads are permitted; they return current contents, which are stale or unswept.
- Reads: combinational, zero latency. data_out_X = read_en_X ? regs[addr_read_X] : 0.
- Writes (RUN only): regs[addr_write] <= data_in on the clk edge; visible on reads the following cycle.
- Scoreboard (RUN only):
  - rsv_en sets busy[rsv_addr].
  - write_en clears busy[addr_write].
  - Same cycle, same address: set wins; the new producer owns the register.
  - Same cycle, different addresses: both take effect.
  - Reserving an already-busy register: busy stays 1, no error.
  - Writing a non-busy register is legal and leaves busy at 0.
- busy_X is combinational from busy[addr_read_X], gated by read_en_X.
- Widths: no arithmetic; addresses are always in range (NUM_REGS is a power of two).

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in RUN, if write_en is high and read_en_X is high and addr_read_X == addr_write, then:
  - data_out_X = data_in in the same cycle;
  - busy_X is forced 0 unless rsv_en targets the same address that cycle.
- Not defined: reads return the pre-write value in the write cycle; busy_X reflects registered state only.

Decomposition:
- Shared package regfile_pkg:
  - state enum (INIT, RUN);
  - function init_value(idx) returning the reset value of register idx.
- Natural sub-module: regfile_scoreboard.
  - Contains the NUM_REGS busy-bit vector with set/clear/priority logic and the two gated busy lookups.
- The data array and FSM stay in regfile_sb.

Test Plan (defaults DATA_W=8, NUM_REGS=4):
- Pulse sync_rst 1 cycle -> ready low for exactly 4 cycles, then high; reading regs 0..3 returns 0x00, 0x01, 0x02, 0x00.
- In RUN: write 0xA5 to r2, read r2 next cycle with read_en_A=1 -> data_out_A = 0xA5. With read_en_A=0 -> data_out_A = 0x00.
- rsv_en to r1, then read r1 -> busy_A = 1. Write 0x3C to r1 -> busy_A = 0 next cycle and data_out_A = 0x3C.
- Same cycle rsv_en r3 and write_en r3 = 0x77 -> r3 reads 0x77 and busy stays 1.
- Assert sync_rst at sweep cycle 2 after a prior write of 0xFF to r3 -> sweep restarts: ready low 4 more cycles; r3 = 0x00; all busy = 0.
- With REGFILE_BYPASS_EN: write 0x5A to r0 while reading r0 on port B -> data_out_B = 0x5A in the same cycle. Without the macro -> old r0 value.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the regfile_sb register file.
// Sweep state encoding and per-index reset values.
package regfile_pkg;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  function automatic int init_value(
    input int idx,
    input int num_regs
  );
    return (idx == num_regs - 1) ? 0 : idx;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bus of the regfile_sb register file.
// master drives reads, writes and reservations; slave is the file.
interface regfile_sb_if #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic              read_en_A;
  logic              read_en_B;
  logic [ADDR_W-1:0] addr_read_A;
  logic [ADDR_W-1:0] addr_read_B;
  logic [DATA_W-1:0] data_out_A;
  logic [DATA_W-1:0] data_out_B;
  logic              busy_A;
  logic              busy_B;
  logic              write_en;
  logic [ADDR_W-1:0] addr_write;
  logic [DATA_W-1:0] data_in;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              ready;

  modport master (
    output read_en_A, read_en_B,
    output addr_read_A, addr_read_B,
    output write_en, addr_write, data_in,
    output rsv_en, rsv_addr,
    input  data_out_A, data_out_B,
    input  busy_A, busy_B, ready
  );

  modport slave (
    input  read_en_A, read_en_B,
    input  addr_read_A, addr_read_B,
    input  write_en, addr_write, data_in,
    input  rsv_en, rsv_addr,
    output data_out_A, data_out_B,
    output busy_A, busy_B, ready
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: reserve sets, write clears, set wins on collision.
// Optional REGFILE_BYPASS_EN hides busy for a register written this cycle.
module regfile_scoreboard #(
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              sync_rst,
  input  logic              run,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] addr_write,
  input  logic              read_en_A,
  input  logic [ADDR_W-1:0] addr_read_A,
  input  logic              read_en_B,
  input  logic [ADDR_W-1:0] addr_read_B,
  output logic              busy_A,
  output logic              busy_B
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (run) begin
      if (write_en) busy_d[addr_write] = 1'b0;
      if (rsv_en)   busy_d[rsv_addr]   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  function automatic logic lookup(
    input logic              en,
    input logic [ADDR_W-1:0] a
  );
    logic b;
    b = en & busy_q[a];
`ifdef REGFILE_BYPASS_EN
    if (run && write_en && en && a == addr_write &&
        !(rsv_en && rsv_addr == a))
      b = 1'b0;
`endif
    return b;
  endfunction

  assign busy_A = lookup(read_en_A, addr_read_A);
  assign busy_B = lookup(read_en_B, addr_read_B);

endmodule

// File: rtl/regfile_sb.sv
// Register file with init sweep, 2 async reads, 1 sync write, scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
import regfile_pkg::*;

module regfile_sb #(
  parameter  int DATA_W   = 8,
  parameter  int NUM_REGS = 4,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input logic         clk,
  input logic         sync_rst,
  regfile_sb_if.slave bus
);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              run;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;

  assign run       = (state_q == RUN);
  assign bus.ready = run;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT: if (cnt_q == ADDR_W'(NUM_REGS - 1)) state_d = RUN;
      RUN:  state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (!run) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Data array has no reset; the sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (!sync_rst) begin
      if (!run)
        regs[cnt_q] <= DATA_W'(init_value(int'(cnt_q), NUM_REGS));
      else if (bus.write_en)
        regs[bus.addr_write] <= bus.data_in;
    end
  end

  always_comb begin
    data_a = bus.read_en_A ? regs[bus.addr_read_A] : '0;
    data_b = bus.read_en_B ? regs[bus.addr_read_B] : '0;
`ifdef REGFILE_BYPASS_EN
    if (run && bus.write_en && bus.read_en_A &&
        bus.addr_read_A == bus.addr_write)
      data_a = bus.data_in;
    if (run && bus.write_en && bus.read_en_B &&
        bus.addr_read_B == bus.addr_write)
      data_b = bus.data_in;
`endif
  end

  assign bus.data_out_A = data_a;
  assign bus.data_out_B = data_b;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_sb (
    .clk         (clk),
    .sync_rst    (sync_rst),
    .run         (run),
    .rsv_en      (bus.rsv_en),
    .rsv_addr    (bus.rsv_addr),
    .write_en    (bus.write_en),
    .addr_write  (bus.addr_write),
    .read_en_A   (bus.read_en_A),
    .addr_read_A (bus.addr_read_A),
    .read_en_B   (bus.read_en_B),
    .addr_read_B (bus.addr_read_B),
    .busy_A      (bus.busy_A),
    .busy_B      (bus.busy_B)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed steps plus random traffic.
// Expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_regfile_sb;

  localparam int DW = 8;
  localparam int NR = 4;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic sync_rst;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(DW), .NUM_REGS(NR)) bus ();

  regfile_sb #(.DATA_W(DW), .NUM_REGS(NR)) dut (
    .clk      (clk),
    .sync_rst (sync_rst),
    .bus      (bus)
  );

  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];
  bit            m_ready;
  int            m_left;
  bit            armed;
  int            errors;
  int            checks;
  int            n;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(bit re, int a);
    if (!re) return 0;
    if (BYP && m_ready && bus.write_en && a == int'(bus.addr_write))
      return 32'(bus.data_in);
    return 32'(m_regs[a]);
  endfunction

  function automatic logic [31:0] exp_busy(bit re, int a);
    if (!re) return 0;
    if (BYP && m_ready && bus.write_en && a == int'(bus.addr_write) &&
        !(bus.rsv_en && a == int'(bus.rsv_addr)))
      return 0;
    return 32'(m_busy[a]);
  endfunction

  task automatic drive(
    input bit rst = 0,
    input bit rea = 0, input int aa = 0,
    input bit reb = 0, input int ab = 0,
    input bit we = 0, input int aw = 0, input int din = 0,
    input bit rsv = 0, input int ra = 0
  );
    sync_rst        = rst;
    bus.read_en_A   = rea;
    bus.addr_read_A = 2'(aa);
    bus.read_en_B   = reb;
    bus.addr_read_B = 2'(ab);
    bus.write_en    = we;
    bus.addr_write  = 2'(aw);
    bus.data_in     = 8'(din);
    bus.rsv_en      = rsv;
    bus.rsv_addr    = 2'(ra);
    #1;
    if (armed) begin
      chk("ready", 32'(bus.ready), 32'(m_ready));
      chk("busy_A", 32'(bus.busy_A), exp_busy(rea, aa));
      chk("busy_B", 32'(bus.busy_B), exp_busy(reb, ab));
      if (m_ready || !rea)
        chk("data_A", 32'(bus.data_out_A), exp_data(rea, aa));
      if (m_ready || !reb)
        chk("data_B", 32'(bus.data_out_B), exp_data(reb, ab));
    end
  endtask

  // Model: after NUM_REGS clean cycles the file holds its init image.
  task automatic tick();
    @(posedge clk);
    if (sync_rst) begin
      m_ready = 0;
      m_left  = NR;
      for (int i = 0; i < NR; i++) m_busy[i] = 0;
    end else if (!m_ready) begin
      m_left--;
      if (m_left == 0) begin
        m_ready = 1;
        for (int i = 0; i < NR; i++)
          m_regs[i] = (i == NR - 1) ? 8'h00 : 8'(i);
      end
    end else begin
      if (bus.write_en) begin
        m_regs[bus.addr_write] = bus.data_in;
        m_busy[bus.addr_write] = 0;
      end
      if (bus.rsv_en) m_busy[bus.rsv_addr] = 1;
    end
    armed = 1;
    @(negedge clk);
  endtask

  task automatic ready_latency(string tag);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      drive();
      if (bus.ready === 1'b1) break;
      n++;
      tick();
    end
    chk(tag, 32'(n), 32'(NR));
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    armed   = 0;
    m_ready = 0;
    m_left  = NR;
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 0;
    end
    @(negedge clk);

    drive(.rst(1)); tick();
    ready_latency("ready_lat");
    for (int i = 0; i < NR; i++) begin
      drive(.rea(1), .aa(i));
      chk("init_val", 32'(bus.data_out_A), (i == 3) ? 0 : i);
      tick();
    end

    drive(.we(1), .aw(2), .din(8'hA5)); tick();
    drive(.rea(1), .aa(2));
    chk("wr_rd", 32'(bus.data_out_A), 32'hA5); tick();
    drive(.rea(0), .aa(2));
    chk("rd_dis", 32'(bus.data_out_A), 32'h00); tick();

    drive(.rsv(1), .ra(1)); tick();
    drive(.rea(1), .aa(1));
    chk("rsv_busy", 32'(bus.busy_A), 1); tick();
    drive(.we(1), .aw(1), .din(8'h3C)); tick();
    drive(.rea(1), .aa(1));
    chk("clr_busy", 32'(bus.busy_A), 0);
    chk("clr_data", 32'(bus.data_out_A), 32'h3C); tick();

    drive(.we(1), .aw(3), .din(8'h77), .rsv(1), .ra(3)); tick();
    drive(.rea(1), .aa(3), .reb(1), .ab(3));
    chk("coll_data", 32'(bus.data_out_A), 32'h77);
    chk("coll_busy", 32'(bus.busy_B), 1); tick();

    drive(.we(1), .aw(0), .din(8'h11)); tick();
    drive(.reb(1), .ab(0), .we(1), .aw(0), .din(8'h5A));
    chk("bypass", 32'(bus.data_out_B), BYP ? 32'h5A : 32'h11);
    tick();
    drive(.reb(1), .ab(0));
    chk("after_byp", 32'(bus.data_out_B), 32'h5A); tick();

    drive(.we(1), .aw(3), .din(8'hFF), .rsv(1), .ra(0)); tick();
    drive(.rsv(1), .ra(2)); tick();
    drive(.rst(1)); tick();
    drive(); tick();
    drive(); tick();
    drive(.rst(1)); tick();
    ready_latency("resweep_lat");
    drive(.rea(1), .aa(3));
    chk("resweep_r3", 32'(bus.data_out_A), 32'h00); tick();
    for (int i = 0; i < NR; i++) begin
      drive(.rea(1), .aa(i));
      chk("rst_busy", 32'(bus.busy_A), 0);
      tick();
    end

    for (int i = 0; i < 400; i++) begin
      drive(.rst($urandom_range(59) == 0),
            .rea(1'($urandom)), .aa(int'($urandom_range(3))),
            .reb(1'($urandom)), .ab(int'($urandom_range(3))),
            .we(1'($urandom)), .aw(int'($urandom_range(3))),
            .din(int'($urandom_range(255))),
            .rsv(1'($urandom)), .ra(int'($urandom_range(3))));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
